// File: rtl/spi_acl2_pkg.sv
// -----------------------------------------------------------------------------
// spi_acl2_pkg
// Shared definitions for the byte-level SPI engine that sits between the
// ADXL362 transaction controller and the SPI pins.
//   - state_t      : FSM state encoding of spi_byte_if
//   - SPI_CPOL/CPHA: SPI mode 0 (clock idles low, sample on leading edge)
//   - DEF_*        : default timing in clk cycles (100 MHz clk -> 1 MHz SCLK)
//   - TMR_W        : width of the CS setup/hold/min-high timer
// -----------------------------------------------------------------------------
package spi_acl2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_BYTE_END,
      ST_GAP,
      ST_HOLD,
      ST_CS_HI
   } state_t;

   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   localparam int DEF_CLK_DIV   = 50;
   localparam int DEF_CS_SETUP  = 10;
   localparam int DEF_CS_HOLD   = 10;
   localparam int DEF_CS_MIN_HI = 20;

   localparam int TMR_W = 16;

endpackage

// File: rtl/spi_byte_if_if.sv
// -----------------------------------------------------------------------------
// spi_byte_if_if
// Byte handshake between the transaction controller (master modport) and the
// SPI byte engine (slave modport).
//   begin_transmission  level, high keeps the CS frame open and sends bytes
//   send_data[7:0]      byte to transmit, sampled at byte start
//   end_transmission    one-clk pulse, byte complete and received_data valid
//   received_data[7:0]  last byte shifted in from miso
//   busy                high from frame start until the CS min-high time ends
// -----------------------------------------------------------------------------
interface spi_byte_if_if;
   logic       begin_transmission;
   logic [7:0] send_data;
   logic       end_transmission;
   logic [7:0] received_data;
   logic       busy;

   modport master (
      output begin_transmission, send_data,
      input  end_transmission, received_data, busy
   );

   modport slave (
      input  begin_transmission, send_data,
      output end_transmission, received_data, busy
   );
endinterface

// File: rtl/spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// spi_sclk_gen
// Half-period counter for one SPI byte. While i_run is high it produces a
// strobe every CLK_DIV clk cycles, alternating rise/fall, starting with the
// low phase. All counters clear whenever i_run is low, so every byte starts
// from a fresh count.
//   clk, rst     system clock, synchronous active-high reset
//   i_run        count enable (high for the whole SHIFT phase)
//   o_rise_stb   SCLK should go high on this clk edge
//   o_fall_stb   SCLK should go low on this clk edge
//   o_bit_done   coincides with the fall strobe of the 8th bit
// -----------------------------------------------------------------------------
module spi_sclk_gen
   import spi_acl2_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic i_run,
   output logic o_rise_stb,
   output logic o_fall_stb,
   output logic o_bit_done
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_phase;   // 0 = SCLK low phase, 1 = SCLK high phase
   logic [2:0]    r_bits;
   logic          w_edge;

   assign w_edge     = i_run && (r_cnt == CW'(CLK_DIV - 1));
   assign o_rise_stb = w_edge && !r_phase;
   assign o_fall_stb = w_edge && r_phase;
   assign o_bit_done = o_fall_stb && (r_bits == 3'd7);

   always_ff @(posedge clk) begin
      if (rst || !i_run) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
         r_bits  <= '0;
      end else if (w_edge) begin
         r_cnt   <= '0;
         r_phase <= ~r_phase;
         if (r_phase) r_bits <= r_bits + 3'd1;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/spi_byte_if.sv
// -----------------------------------------------------------------------------
// spi_byte_if
// Byte-level SPI mode-0 engine. Opens a CS frame when begin_transmission is
// seen in IDLE, shifts bytes MSB-first on mosi while capturing miso, pulses
// end_transmission per byte and keeps the frame open for as long as the
// controller holds begin_transmission. All outputs are registered.
//   clk, rst      system clock, synchronous active-high reset
//   ifc (slave)   begin_transmission, send_data, end_transmission,
//                 received_data, busy
//   chip_select   SPI CS (1 = idle)
//   sclk          SPI clock, idles low
//   mosi / miso   serial data out / in
// Build option SPI_MISO_SYNC_EN: miso goes through a 2-FF synchronizer and is
// captured 2 clk after the SCLK rise (needs CLK_DIV >= 3).
// -----------------------------------------------------------------------------
module spi_byte_if
   import spi_acl2_pkg::*;
#(
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int CS_SETUP  = DEF_CS_SETUP,
   parameter int CS_HOLD   = DEF_CS_HOLD,
   parameter int CS_MIN_HI = DEF_CS_MIN_HI
) (
   input  logic         clk,
   input  logic         rst,
   spi_byte_if_if.slave ifc,
   output logic         chip_select,
   output logic         sclk,
   output logic         mosi,
   input  logic         miso
);

   state_t           r_state, w_state_nxt;
   logic [TMR_W-1:0] r_tmr;
   logic             w_tmr_done;
   logic             w_run, w_rise, w_fall, w_bit_done;
   logic             w_cap_edge, w_samp, w_miso, w_load;
   logic [6:0]       r_tx_sr;   // bits still to send after the one on mosi
   logic [7:0]       r_rx_sr, r_rx_data;
   logic             r_cs, r_sclk, r_mosi, r_end, r_busy;

   assign w_run = (r_state == ST_SHIFT);

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk        (clk),
      .rst        (rst),
      .i_run      (w_run),
      .o_rise_stb (w_rise),
      .o_fall_stb (w_fall),
      .o_bit_done (w_bit_done)
   );

   // Mode 0 samples on the leading (rising) SCLK edge.
   assign w_cap_edge = (SPI_CPHA == 1'b0) ? w_rise : w_fall;

`ifdef SPI_MISO_SYNC_EN
   logic [1:0] r_miso_sync, r_cap_d;
   always_ff @(posedge clk) begin
      r_miso_sync <= {r_miso_sync[0], miso};
      if (rst) r_cap_d <= '0;
      else     r_cap_d <= {r_cap_d[0], w_cap_edge};
   end
   // Delaying the capture strobe by the synchronizer depth keeps the sample
   // aligned with the miso value present at the SCLK rise.
   assign w_miso = r_miso_sync[1];
   assign w_samp = r_cap_d[1];
`else
   assign w_miso = miso;
   assign w_samp = w_cap_edge;
`endif

   // A byte is loaded either when a frame opens or when the controller keeps
   // the frame going after the GAP cycle.
   assign w_load = ifc.begin_transmission && ((r_state == ST_IDLE) || (r_state == ST_GAP));

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tmr_done  = 1'b0;
      unique case (r_state)
         ST_IDLE:     if (ifc.begin_transmission) w_state_nxt = ST_SETUP;
         ST_SETUP: begin
            w_tmr_done = (r_tmr == TMR_W'(CS_SETUP - 1));
            if (w_tmr_done) w_state_nxt = ST_SHIFT;
         end
         ST_SHIFT:    if (w_bit_done) w_state_nxt = ST_BYTE_END;
         ST_BYTE_END: w_state_nxt = ST_GAP;
         ST_GAP:      w_state_nxt = ifc.begin_transmission ? ST_SHIFT : ST_HOLD;
         ST_HOLD: begin
            w_tmr_done = (r_tmr == TMR_W'(CS_HOLD - 1));
            if (w_tmr_done) w_state_nxt = ST_CS_HI;
         end
         ST_CS_HI: begin
            w_tmr_done = (r_tmr == TMR_W'(CS_MIN_HI - 1));
            if (w_tmr_done) w_state_nxt = ST_IDLE;
         end
         default:     w_state_nxt = ST_IDLE;
      endcase
   end

   // Timer restarts on every state change and only runs in the timed states.
   always_ff @(posedge clk) begin
      if (rst || (w_state_nxt != r_state))
         r_tmr <= '0;
      else if ((r_state == ST_SETUP) || (r_state == ST_HOLD) || (r_state == ST_CS_HI))
         r_tmr <= r_tmr + TMR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cs      <= 1'b1;
         r_sclk    <= SPI_CPOL;
         r_mosi    <= 1'b0;
         r_end     <= 1'b0;
         r_rx_data <= 8'h00;
         r_busy    <= 1'b0;
      end else begin
         r_end <= w_bit_done;
         if (w_bit_done) r_rx_data <= r_rx_sr;

         if (w_rise)      r_sclk <= 1'b1;
         else if (w_fall) r_sclk <= 1'b0;

         // mosi keeps the last bit after the 8th fall until the next load.
         if (w_load)                     r_mosi <= ifc.send_data[7];
         else if (w_fall && !w_bit_done) r_mosi <= r_tx_sr[6];

         if ((r_state == ST_IDLE) && ifc.begin_transmission) begin
            r_cs   <= 1'b0;
            r_busy <= 1'b1;
         end
         if ((r_state == ST_HOLD) && w_tmr_done)  r_cs   <= 1'b1;
         if ((r_state == ST_CS_HI) && w_tmr_done) r_busy <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_load)                     r_tx_sr <= ifc.send_data[6:0];
      else if (w_fall && !w_bit_done) r_tx_sr <= {r_tx_sr[5:0], 1'b0};
      if (w_samp) r_rx_sr <= {r_rx_sr[6:0], w_miso};
   end

   assign chip_select          = r_cs;
   assign sclk                 = r_sclk;
   assign mosi                 = r_mosi;
   assign ifc.end_transmission = r_end;
   assign ifc.received_data    = r_rx_data;
   assign ifc.busy             = r_busy;

endmodule

// File: tb/tb_spi_byte_if.sv
// -----------------------------------------------------------------------------
// tb_spi_byte_if
// Directed bench for spi_byte_if. The bench plays the transaction controller
// and an SPI mode-0 slave, and a protocol model checks every frame: CS setup,
// SCLK period, bits per byte, byte spacing, CS hold, CS minimum high time and
// the transmitted/received bytes. With SPI_MISO_SYNC_EN defined the design is
// built with CLK_DIV=3, otherwise CLK_DIV=2; expected bytes are identical.
// -----------------------------------------------------------------------------
module tb_spi_byte_if;
`ifdef SPI_MISO_SYNC_EN
   localparam int CLK_DIV = 3;
`else
   localparam int CLK_DIV = 2;
`endif
   localparam int CS_SETUP  = 2;
   localparam int CS_HOLD   = 2;
   localparam int CS_MIN_HI = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic miso = 1'b0;
   logic chip_select, sclk, mosi;

   spi_byte_if_if ifc();

   spi_byte_if #(
      .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_MIN_HI(CS_MIN_HI)
   ) dut (
      .clk(clk), .rst(rst), .ifc(ifc),
      .chip_select(chip_select), .sclk(sclk), .mosi(mosi), .miso(miso)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- expectation queues and slave model ----------------
   logic [7:0] exp_tx_q[$];
   logic [7:0] exp_rx_q[$];
   logic [7:0] rsp_q[$];

   logic       s_pcs = 1'b1, s_psclk = 1'b0;
   logic [7:0] s_cur = 8'h00;
   int         s_bit = 0;

   // Mode-0 slave: first bit valid when CS falls, next bit after each SCLK fall.
   always @(negedge clk) begin
      if (rst) begin
         s_pcs = chip_select; s_psclk = sclk; miso = 1'b0;
      end else begin
         if (s_pcs && !chip_select) begin
            s_cur = (rsp_q.size() != 0) ? rsp_q.pop_front() : 8'h00;
            s_bit = 0;
            miso  = s_cur[7];
         end else if (s_psclk && !sclk && !chip_select) begin
            s_bit++;
            if (s_bit == 8) begin
               s_cur = (rsp_q.size() != 0) ? rsp_q.pop_front() : 8'h00;
               s_bit = 0;
            end
            miso = s_cur[7 - s_bit];
         end
         s_pcs = chip_select; s_psclk = sclk;
      end
   end

   // ---------------- protocol model / compare process ----------------
   logic        p_cs = 1'b1, p_sclk = 1'b0, p_busy = 1'b0;
   int          t_csfall = 0, t_csrise = -1000, t_end = 0, t_rise = 0;
   int          n_rise_byte = 0, n_rise_tot = 0, n_end_tot = 0, n_csfall_tot = 0;
   logic        first_rise = 1'b1, first_byte = 1'b1;
   logic [7:0]  tx_acc = 8'h00;
   logic [63:0] mosi_log = 64'h0;

   always @(negedge clk) begin
      if (rst) begin
         exp_tx_q.delete(); exp_rx_q.delete();
         n_rise_byte = 0; first_rise = 1'b1; first_byte = 1'b1;
      end else begin
         if (p_cs && !chip_select) begin
            chk("cs_fall_busy", ifc.busy, 1);
            chk("cs_min_hi", 32'(cyc - t_csrise >= CS_MIN_HI + 1), 1);
            t_csfall = cyc; first_rise = 1'b1; first_byte = 1'b1; n_rise_byte = 0;
            n_csfall_tot++;
         end
         if (!p_cs && chip_select) begin
            chk("cs_hold", cyc - t_end, CS_HOLD + 2);
            t_csrise = cyc;
         end
         if (p_busy && !ifc.busy) chk("busy_fall", cyc - t_csrise, CS_MIN_HI);
         if (!p_sclk && sclk) begin
            chk("rise_cs_low", chip_select, 0);
            if (first_rise)       chk("cs_setup", cyc - t_csfall, CS_SETUP + CLK_DIV);
            else if (n_rise_byte != 0) chk("sclk_period", cyc - t_rise, 2 * CLK_DIV);
            first_rise = 1'b0; t_rise = cyc;
            tx_acc   = {tx_acc[6:0], mosi};
            mosi_log = {mosi_log[62:0], mosi};
            n_rise_byte++; n_rise_tot++;
         end
         if (ifc.end_transmission) begin
            chk("bits_per_byte", n_rise_byte, 8);
            chk("end_after_rise", cyc - t_rise, CLK_DIV);
            chk("end_sclk_low", sclk, 0);
            if (!first_byte) chk("byte_period", cyc - t_end, 16 * CLK_DIV + 2);
            chk("end_expected", 32'(exp_tx_q.size() != 0), 1);
            if (exp_tx_q.size() != 0) begin
               chk("tx_byte", tx_acc, exp_tx_q.pop_front());
               chk("rx_byte", ifc.received_data, exp_rx_q.pop_front());
            end
            first_byte = 1'b0; t_end = cyc; n_rise_byte = 0; n_end_tot++;
         end
      end
      p_cs = chip_select; p_sclk = sclk; p_busy = ifc.busy;
   end

   // ---------------- controller-side helpers ----------------
   task automatic wait_end(output logic ok);
      ok = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         if (ifc.end_transmission) begin ok = 1'b1; break; end
      end
      chk("end_seen", ok, 1);
   endtask

   task automatic wait_idle();
      logic ok = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         if (!ifc.busy && chip_select) begin ok = 1'b1; break; end
      end
      chk("idle_seen", ok, 1);
   endtask

   task automatic wait_cs(input logic lvl);
      logic ok = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         if (chip_select == lvl) begin ok = 1'b1; break; end
      end
      chk("cs_level_seen", ok, 1);
   endtask

   task automatic wait_rises(input int n);
      logic ok = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         if (n_rise_byte >= n) begin ok = 1'b1; break; end
      end
      chk("rises_seen", ok, 1);
   endtask

   task automatic expect_byte(input logic [7:0] tx, input logic [7:0] rx);
      exp_tx_q.push_back(tx); exp_rx_q.push_back(rx); rsp_q.push_back(rx);
   endtask

   // Bytes are packed first-byte-in-MSB.
   task automatic run_frame(input logic [63:0] txv, input logic [63:0] rxv, input int n);
      logic ok;
      for (int i = 0; i < n; i++) expect_byte(txv[63 - 8*i -: 8], rxv[63 - 8*i -: 8]);
      ifc.send_data = txv[63:56];
      ifc.begin_transmission = 1'b1;
      for (int i = 0; i < n; i++) begin
         wait_end(ok);
         if (!ok) break;
         if (i + 1 < n) ifc.send_data = txv[63 - 8*(i+1) -: 8];
         else           ifc.begin_transmission = 1'b0;
      end
      ifc.begin_transmission = 1'b0;
      wait_idle();
   endtask

   task automatic clr_stats();
      n_rise_tot = 0; n_end_tot = 0; n_csfall_tot = 0; mosi_log = 64'h0;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      int   te, tr;
      ifc.begin_transmission = 1'b0;
      ifc.send_data = 8'h00;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_cs", chip_select, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_end", ifc.end_transmission, 0);
      chk("rst_rx", ifc.received_data, 8'h00);
      chk("rst_busy", ifc.busy, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Write frame 0x0A 0x2D 0x0A in one CS window.
      clr_stats();
      run_frame({8'h0A, 8'h2D, 8'h0A, 40'h0}, {8'h5A, 8'h96, 8'h00, 40'h0}, 3);
      chk("t1_mosi_stream", mosi_log[23:0], 24'h0A2D0A);
      chk("t1_rises", n_rise_tot, 24);
      chk("t1_ends", n_end_tot, 3);
      chk("t1_cs_windows", n_csfall_tot, 1);

      // Read burst: command 0x0B, address 0x0E, then 6 data bytes.
      clr_stats();
      run_frame({8'h0B, 8'h0E, 48'h0}, {8'hC3, 8'h3C, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16}, 8);
      chk("t2_last_rx", ifc.received_data, 8'h16);
      chk("t2_ends", n_end_tot, 8);
      chk("t2_rises", n_rise_tot, 64);

      // Reset in the middle of a byte.
      expect_byte(8'h3C, 8'h99);
      ifc.send_data = 8'h3C;
      ifc.begin_transmission = 1'b1;
      wait_rises(4);
      rst = 1'b1;
      ifc.begin_transmission = 1'b0;
      @(negedge clk);
      chk("t3_cs", chip_select, 1);
      chk("t3_sclk", sclk, 0);
      chk("t3_end", ifc.end_transmission, 0);
      chk("t3_busy", ifc.busy, 0);
      chk("t3_rx", ifc.received_data, 8'h00);
      @(negedge clk);
      chk("t3_end2", ifc.end_transmission, 0);
      @(negedge clk);
      rst = 1'b0;
      rsp_q.delete();
      @(negedge clk);
      run_frame({8'hC6, 56'h0}, {8'h6C, 56'h0}, 1);
      chk("t3_clean_rx", ifc.received_data, 8'h6C);

      // Begin dropped in the end cycle, then reasserted during CS high time.
      expect_byte(8'h5A, 8'hA7);
      ifc.send_data = 8'h5A;
      ifc.begin_transmission = 1'b1;
      wait_end(ok);
      ifc.begin_transmission = 1'b0;
      te = cyc;
      wait_cs(1'b1);
      tr = cyc;
      chk("t4_cs_rise", tr - te, 4);
      expect_byte(8'h81, 8'h18);
      ifc.send_data = 8'h81;
      ifc.begin_transmission = 1'b1;
      wait_cs(1'b0);
      chk("t4_cs_high_time", cyc - tr, 4);
      wait_end(ok);
      ifc.begin_transmission = 1'b0;
      wait_idle();
      chk("t4_rx", ifc.received_data, 8'h18);

      // send_data changes mid-byte.
      clr_stats();
      expect_byte(8'hA5, 8'h3E);
      ifc.send_data = 8'hA5;
      ifc.begin_transmission = 1'b1;
      wait_rises(3);
      ifc.send_data = 8'hFF;
      wait_end(ok);
      ifc.begin_transmission = 1'b0;
      wait_idle();
      chk("t5_mosi_byte", mosi_log[7:0], 8'hA5);
      chk("t5_rx", ifc.received_data, 8'h3E);

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
